// File: rtl/flexbex_efpga_ctrl_multi_if.sv
// Core/fabric signal bundle for the eFPGA custom-instruction controller.
// master = core + fabric side (drives requests/results), slave = controller.
interface flexbex_efpga_ctrl_multi_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_RESULTS = 4,
  parameter int DELAY_WIDTH = 4,
  parameter int SEL_W       = $clog2(NUM_RESULTS)
);
  logic                              en_i;
  logic [SEL_W-1:0]                  operator_i;
  logic                              strobe_req_i;
  logic [DELAY_WIDTH-1:0]            delay_i;
  logic [NUM_RESULTS*DATA_WIDTH-1:0] result_i;
  logic                              efpga_done_i;
  logic                              ready_o;
  logic [DATA_WIDTH-1:0]             endresult_o;
  logic                              write_strobe_o;
  logic                              busy_o;
  logic                              error_o;

  modport master (
    output en_i, operator_i, strobe_req_i, delay_i, result_i, efpga_done_i,
    input  ready_o, endresult_o, write_strobe_o, busy_o, error_o
  );

  modport slave (
    input  en_i, operator_i, strobe_req_i, delay_i, result_i, efpga_done_i,
    output ready_o, endresult_o, write_strobe_o, busy_o, error_o
  );
endinterface

// File: rtl/flexbex_efpga_ctrl_multi.sv
// eFPGA result controller: latency 1+delay (fixed) or done+1 (handshake); one request in flight, en_i ignored while busy.
// Optional done-mode timeout with error reporting under `define EFPGA_TIMEOUT_EN.
module flexbex_efpga_ctrl_multi #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_RESULTS    = 4,
  parameter int DELAY_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SEL_W          = $clog2(NUM_RESULTS)
) (
  input logic clk,
  input logic rst_n,
  flexbex_efpga_ctrl_multi_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [DELAY_WIDTH-1:0] DLY_HANDSHAKE = '1;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q;
  logic [DELAY_WIDTH-1:0] dly_q;
  logic [DELAY_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0]  endres_q;
  logic                   wstrb_q;
  logic                   err_q;
  logic [DATA_WIDTH-1:0]  sel_res;
  logic                   accept;
  logic                   capture;
  logic                   tmo;
  logic                   tmo_hit;
  logic                   done_mode;

  assign done_mode = (dly_q == DLY_HANDSHAKE);

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    sel_res = bus.result_i[0 +: DATA_WIDTH];
    for (int n = 0; n < NUM_RESULTS; n++) begin
      if (sel_q == SEL_W'(n)) sel_res = bus.result_i[n*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef EFPGA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  assign tmo_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (accept) begin
      to_cnt_q <= '0;
    end else if (state_q == S_WAIT && done_mode && !capture && !tmo) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en_i) begin
          accept  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!done_mode) begin
          capture = (cnt_q == dly_q);
        end else if (bus.efpga_done_i) begin
          capture = 1'b1;
        end else begin
          tmo = tmo_hit;
        end
        if (capture || tmo) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      dly_q    <= '0;
      cnt_q    <= '0;
      endres_q <= '0;
      wstrb_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q   <= bus.operator_i;
        dly_q   <= bus.delay_i;
        cnt_q   <= '0;
        wstrb_q <= bus.strobe_req_i;
      end else if (state_q == S_WAIT && !done_mode && !capture) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) begin
        endres_q <= sel_res;
        wstrb_q  <= 1'b0;
        err_q    <= 1'b0;
      end else if (tmo) begin
        endres_q <= '1;
        wstrb_q  <= 1'b0;
        err_q    <= 1'b1;
      end
    end
  end

  assign bus.ready_o        = (state_q == S_DONE);
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.endresult_o    = endres_q;
  assign bus.write_strobe_o = wstrb_q;
  assign bus.error_o        = err_q;

endmodule

// File: tb/tb_flexbex_efpga_ctrl_multi.sv
// Bench for flexbex_efpga_ctrl_multi: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an edge-arithmetic transaction model.
module tb_flexbex_efpga_ctrl_multi;
  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int DLW = 4;
  localparam int TO  = 8;
  localparam int SW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flexbex_efpga_ctrl_multi_if #(.DATA_WIDTH(DW), .NUM_RESULTS(NR), .DELAY_WIDTH(DLW)) ifc ();

  flexbex_efpga_ctrl_multi #(
    .DATA_WIDTH(DW), .NUM_RESULTS(NR), .DELAY_WIDTH(DLW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request accepted at edge s completes at edge s+1+delay,
  // at the first edge after s where done is seen, or (timeout build) at s+TO.
  int            edge_n = 0;
  bit            cmp_en = 0;
  bit            m_act, m_rdy, fin, to_hit;
  int            m_start, idx;
  logic [SW-1:0] m_sel;
  logic [DLW-1:0] m_dly;
  logic [DW-1:0] m_res;
  logic          m_ws, m_err;

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      m_act = 0; m_rdy = 0; m_res = '0; m_ws = 0; m_err = 0;
      cmp_en = 1;
    end else if (m_rdy) begin
      m_rdy = 0;
    end else if (!m_act) begin
      if (ifc.en_i) begin
        m_act   = 1;
        m_start = edge_n;
        m_sel   = ifc.operator_i;
        m_dly   = ifc.delay_i;
        m_ws    = ifc.strobe_req_i;
      end
    end else begin
      fin = 0; to_hit = 0;
      if (m_dly != {DLW{1'b1}}) fin = (edge_n == m_start + 1 + int'(m_dly));
      else if (ifc.efpga_done_i) fin = 1;
`ifdef EFPGA_TIMEOUT_EN
      else if (edge_n == m_start + TO) begin fin = 1; to_hit = 1; end
`endif
      if (fin) begin
        idx   = (int'(m_sel) < NR) ? int'(m_sel) : 0;
        m_res = to_hit ? {DW{1'b1}} : ifc.result_i[idx*DW +: DW];
        m_ws  = 0;
        m_err = to_hit;
        m_act = 0;
        m_rdy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready_o", ifc.ready_o, m_rdy);
      chk("busy_o", ifc.busy_o, m_act | m_rdy);
      chk("endresult_o", ifc.endresult_o, m_res);
      chk("write_strobe_o", ifc.write_strobe_o, m_ws);
      chk("error_o", ifc.error_o, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    ifc.en_i = 0;
    ifc.efpga_done_i = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (ifc.ready_o !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  int n, pulses, ready_at;

  initial begin
    ifc.en_i = 0; ifc.operator_i = '0; ifc.strobe_req_i = 0; ifc.delay_i = '0;
    ifc.result_i = '0; ifc.efpga_done_i = 0;
    do_reset();
    chk("rst_endresult", ifc.endresult_o, 0);
    chk("rst_ready", ifc.ready_o, 0);
    chk("rst_wstrb", ifc.write_strobe_o, 0);
    chk("rst_busy", ifc.busy_o, 0);
    chk("rst_error", ifc.error_o, 0);

    // Fixed delay 3 on channel 2; operator change after acceptance must not matter.
    ifc.result_i = {32'h33333333, 32'hCAFEF00D, 32'h11111111, 32'h00000000};
    ifc.en_i = 1; ifc.operator_i = 2'd2; ifc.delay_i = 4'd3; ifc.strobe_req_i = 0;
    step();
    ifc.en_i = 0; ifc.operator_i = 2'd1; ifc.delay_i = 4'd0;
    wait_ready(20, n);
    chk("fixed_latency", n, 4);
    chk("fixed_result", ifc.endresult_o, 32'hCAFEF00D);
    step();
    chk("fixed_ready_drop", ifc.ready_o, 0);

    // Handshake mode with write strobe.
    ifc.result_i = {32'h33333333, 32'h22222222, 32'h12345678, 32'h00000000};
    ifc.en_i = 1; ifc.operator_i = 2'd1; ifc.delay_i = 4'hF; ifc.strobe_req_i = 1;
    step();
    ifc.en_i = 0;
    chk("done_wstrb_start", ifc.write_strobe_o, 1);
    repeat (9) step();
    chk("done_wstrb_hold", ifc.write_strobe_o, 1);
    chk("done_no_ready", ifc.ready_o, 0);
    ifc.efpga_done_i = 1;
    step();
    ifc.efpga_done_i = 0;
    chk("done_ready", ifc.ready_o, 1);
    chk("done_wstrb_clr", ifc.write_strobe_o, 0);
    chk("done_result", ifc.endresult_o, 32'h12345678);
    step();
    chk("done_idle", ifc.busy_o, 0);

    // Requests while busy are ignored.
    ifc.strobe_req_i = 0; ifc.delay_i = 4'd2; ifc.operator_i = 2'd0;
    pulses = 0; ready_at = -1;
    for (int i = 0; i < 10; i++) begin
      ifc.en_i = (i == 0 || i == 1 || i == 3);
      step();
      if (ifc.ready_o) begin pulses++; ready_at = i; end
    end
    ifc.en_i = 0;
    chk("ignored_pulses", pulses, 1);
    chk("ignored_ready_at", ready_at, 3);

    ifc.en_i = 1; ifc.delay_i = 4'd0;
    step();
    ifc.en_i = 0;
    step();
    chk("delay0_ready", ifc.ready_o, 1);
    step();

    // Reset in the middle of a delay-7 wait.
    ifc.en_i = 1; ifc.delay_i = 4'd7; ifc.strobe_req_i = 1;
    step();
    ifc.en_i = 0;
    repeat (3) step();
    rst_n = 0;
    step();
    rst_n = 1;
    chk("midrst_busy", ifc.busy_o, 0);
    chk("midrst_wstrb", ifc.write_strobe_o, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ifc.ready_o) pulses++;
    end
    chk("midrst_no_ready", pulses, 0);

    // Handshake mode where the fabric never answers.
    ifc.en_i = 1; ifc.delay_i = 4'hF; ifc.strobe_req_i = 1; ifc.operator_i = 2'd3;
    step();
    ifc.en_i = 0;
`ifdef EFPGA_TIMEOUT_EN
    wait_ready(20, n);
    chk("tmo_latency", n, TO);
    chk("tmo_error", ifc.error_o, 1);
    chk("tmo_result", ifc.endresult_o, 32'hFFFFFFFF);
    chk("tmo_wstrb", ifc.write_strobe_o, 0);
`else
    repeat (100) step();
    chk("no_tmo_busy", ifc.busy_o, 1);
    ifc.efpga_done_i = 1;
    step();
    ifc.efpga_done_i = 0;
    chk("no_tmo_release", ifc.ready_o, 1);
`endif
    do_reset();

    // Randomized traffic, checked by the per-cycle compare.
    for (int i = 0; i < 800; i++) begin
      ifc.en_i         = ($urandom_range(0, 2) == 0);
      ifc.operator_i   = SW'($urandom_range(0, NR - 1));
      ifc.strobe_req_i = $urandom_range(0, 1) == 1;
      ifc.delay_i      = ($urandom_range(0, 3) == 0) ? 4'hF : DLW'($urandom_range(0, 14));
      ifc.efpga_done_i = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < NR; c++) ifc.result_i[c*DW +: DW] = $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    do_reset();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flexbex_efpga_ctrl_multi.md
# flexbex_efpga_ctrl_multi

Parametrised eFPGA custom-instruction controller sitting between the flexbex ibex execute stage and the eFPGA fabric. On a core request it selects one of NUM_RESULTS fabric result channels, waits either a programmed fixed delay or the fabric's done handshake, registers the chosen result and pulses ready back to the core. Compared with the fixed 3-channel version it adds configurable width and channel count, request-time latching of all control inputs, a busy indication, and an optional done-mode timeout with error reporting.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each result channel and of endresult_o
- NUM_RESULTS, 4, number of result channels (>=2)
- DELAY_WIDTH, 4, width of delay_i; all-ones value selects done-handshake mode
- TIMEOUT_CYCLES, 1024, done-mode timeout (used only with EFPGA_TIMEOUT_EN), >=1
- SEL_W, $clog2(NUM_RESULTS), derived, width of operator_i

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en_i  in  1  request strobe from core
- operator_i  in  SEL_W  result channel select
- strobe_req_i  in  1  request write_strobe_o for this operation
- delay_i  in  DELAY_WIDTH  fixed wait count; all-ones = wait for efpga_done_i
- result_i  in  NUM_RESULTS*DATA_WIDTH  flattened channels, channel n at [n*DATA_WIDTH +: DATA_WIDTH]
- efpga_done_i  in  1  fabric completion (level, sampled in WAIT only)
- ready_o  out  1  one-cycle completion pulse
- endresult_o  out  DATA_WIDTH  registered selected result
- write_strobe_o  out  1  write strobe to fabric
- busy_o  out  1  high when not IDLE
- error_o  out  1  timeout flag, valid with ready_o

## Operation
- States IDLE, WAIT, DONE. Reset: state IDLE, counters 0, endresult_o 0, write_strobe_o 0, error_o 0; ready_o/busy_o derived, hence 0.
- IDLE: en_i=1 latches operator_i, delay_i, strobe_req_i; clears cycle counter; -> WAIT. write_strobe_o <= strobe_req_i.
- en_i in WAIT or DONE is ignored; inputs are not re-latched.
- WAIT, fixed mode (latched delay != all-ones): counter increments each cycle; when counter == latched delay -> capture, -> DONE.
- WAIT, done mode: efpga_done_i=1 -> capture, -> DONE. Counter not used for completion.
- Capture: endresult_o <= channel[latched sel]; sel >= NUM_RESULTS selects channel 0; write_strobe_o <= 0; error_o <= 0.
- DONE: ready_o=1 for exactly this cycle; -> IDLE unconditionally. endresult_o holds until next capture.
- busy_o = (state != IDLE); ready_o = (state == DONE).
- Counter width DELAY_WIDTH; cannot wrap in fixed mode (max compare value is all-ones minus 1).
- Reset mid-operation: immediate return to IDLE, all outputs to reset values, no ready_o.

## Timing
- en_i sampled at edge k -> WAIT from k; fixed mode: capture at edge k+1+delay, ready_o high in cycle after that edge (delay 0 -> ready_o after edge k+1).
- Done mode: efpga_done_i high at edge j (state WAIT) -> capture at j, ready_o following cycle. efpga_done_i in IDLE/DONE ignored.
- write_strobe_o high from edge k to capture edge when strobe_req_i latched 1.
- Back-to-back: en_i held high re-enters WAIT at the edge leaving DONE-> IDLE's next edge (minimum 3-cycle request spacing: IDLE, WAIT, DONE).

## Configuration
- Macro EFPGA_TIMEOUT_EN.
- Defined: done mode has timeout counter ($clog2(TIMEOUT_CYCLES+1) bits) cleared at en_i; if it reaches TIMEOUT_CYCLES in WAIT without efpga_done_i -> DONE with endresult_o = all-ones, error_o = 1, write_strobe_o = 0. done and timeout in same cycle: done wins, error_o 0.
- Undefined: no timeout logic; done mode waits indefinitely; error_o tied 0.

## Test plan
- Reset then idle: rst_n low 2 cycles -> endresult_o=0, ready_o=0, write_strobe_o=0, busy_o=0.
- Fixed delay: en_i, operator_i=2, delay_i=3, ch2=0xCAFEF00D -> ready_o pulse in cycle after edge k+4, endresult_o=0xCAFEF00D; operator_i changed after k has no effect.
- Done mode with strobe: delay_i=4'hF, strobe_req_i=1, ch1=0x12345678, efpga_done_i after 10 cycles -> write_strobe_o high until capture, ready_o one cycle later, endresult_o=0x12345678.
- Ignored request: en_i pulses while busy_o=1 -> exactly one ready_o pulse; delay_i=0 gives ready_o after edge k+1.
- Timeout (macro on, TIMEOUT_CYCLES=8): done mode, efpga_done_i never high -> ready_o and error_o after 8 WAIT cycles, endresult_o=0xFFFFFFFF; macro off -> busy_o stays 1 after 100 cycles.
- Reset mid-WAIT: rst_n low during fixed delay 7 at count 3 -> IDLE, no ready_o, write_strobe_o=0.
